// File: rtl/regfile_pkg.sv
// Shared constants for the register file / pending-write scoreboard slice.
package regfile_pkg;

  // Default geometry of the MIPS integer register file.
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NREGS  = 32;

  // Address of the hardwired zero register.
  localparam int unsigned REG_ZERO_ADDR = 0;

endpackage : regfile_pkg

// File: rtl/rf_pending_tracker.sv
// Per-register pending-write bits plus an incrementally maintained count.
// Issue/write strobes arrive already qualified (zero register filtered out).
module rf_pending_tracker
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_write_addr,
  input  logic              i_issue_en,
  input  logic [ADDR_W-1:0] i_issue_addr,
  input  logic              i_flush,
  output logic [NREGS-1:0]  o_pending,
  output logic [ADDR_W:0]   o_count
);

  logic [NREGS-1:0] r_pending;
  logic [ADDR_W:0]  r_count;
  logic [NREGS-1:0] w_pending_next;
  logic             w_inc;
  logic             w_dec;

  // Next pending vector: writeback clears first, then an issue re-sets, so a
  // same-address issue wins (the newer instruction owns the register).
  // The count moves by one for each bit that actually changes state.
  always_comb begin
    w_pending_next = r_pending;
    w_inc          = 1'b0;
    w_dec          = 1'b0;
    if (i_write_en) begin
      w_pending_next[i_write_addr] = 1'b0;
      w_dec = r_pending[i_write_addr] &&
              !(i_issue_en && (i_issue_addr == i_write_addr));
    end
    if (i_issue_en) begin
      w_pending_next[i_issue_addr] = 1'b1;
      w_inc = !r_pending[i_issue_addr];
    end
  end

  // Pending state register: reset over flush over normal update.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
      r_count   <= '0;
    end else if (i_flush) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_count   <= r_count + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
    end
  end

  assign o_pending = r_pending;
  assign o_count   = r_count;

endmodule : rf_pending_tracker

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass, optional
// hardwired zero register, and a pending-write scoreboard for stall control.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned ADDR_W   = $clog2(NREGS),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] IssueAddr,
  input  logic              Flush,
  output logic [ADDR_W:0]   PendingCount
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  w_pending;
  logic              w_write_ok;
  logic              w_issue_ok;

  // Writes and issues aimed at the hardwired zero register are ignored.
  assign w_write_ok = RegWrite && !(ZERO_REG && (WriteAddr == ZERO_ADDR));
  assign w_issue_ok = Issue    && !(ZERO_REG && (IssueAddr == ZERO_ADDR));

  // Data array: reset clears every entry, otherwise take the writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_write_ok) begin
      r_regs[WriteAddr] <= WriteData;
    end
  end

  rf_pending_tracker #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .i_write_en  (w_write_ok),
    .i_write_addr(WriteAddr),
    .i_issue_en  (w_issue_ok),
    .i_issue_addr(IssueAddr),
    .i_flush     (Flush),
    .o_pending   (w_pending),
    .o_count     (PendingCount)
  );

  // Read port 1: zero register, then same-cycle bypass, then array.
  // A bypassed value is the completing write, so it is never busy.
  always_comb begin
    ReadData1 = r_regs[ReadAddr1];
    Busy1     = w_pending[ReadAddr1];
    if (ZERO_REG && (ReadAddr1 == ZERO_ADDR)) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end else if (RegWrite && (WriteAddr == ReadAddr1)) begin
      ReadData1 = WriteData;
      Busy1     = 1'b0;
    end
  end

  // Read port 2: same selection order as port 1.
  always_comb begin
    ReadData2 = r_regs[ReadAddr2];
    Busy2     = w_pending[ReadAddr2];
    if (ZERO_REG && (ReadAddr2 == ZERO_ADDR)) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end else if (RegWrite && (WriteAddr == ReadAddr2)) begin
      ReadData2 = WriteData;
      Busy2     = 1'b0;
    end
  end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table followed by random
// traffic compared against a behavioural model of the register file.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadAddr1, ReadAddr2;
  logic [DW-1:0] ReadData1, ReadData2;
  logic          Busy1, Busy2;
  logic          Issue;
  logic [AW-1:0] IssueAddr;
  logic          Flush;
  logic [AW:0]   PendingCount;

  int n_pass  = 0;
  int n_total = 0;

  regfile_scoreboard #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clock(clk), .reset(reset), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Busy1(Busy1), .Busy2(Busy2),
    .Issue(Issue), .IssueAddr(IssueAddr), .Flush(Flush), .PendingCount(PendingCount)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          iss;
    logic [AW-1:0] ia;
    logic          fl;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e_rd1;
    logic [DW-1:0] e_rd2;
    logic          e_b1;
    logic          e_b2;
    logic [AW:0]   e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic we, int wa, logic [DW-1:0] wd,
                              logic iss, int ia, logic fl, int ra1, int ra2,
                              logic [DW-1:0] e_rd1, logic [DW-1:0] e_rd2,
                              logic e_b1, logic e_b2, int e_cnt);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = AW'(wa); v.wd = wd;
    v.iss = iss; v.ia = AW'(ia); v.fl = fl;
    v.ra1 = AW'(ra1); v.ra2 = AW'(ra2);
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_cnt = (AW+1)'(e_cnt);
    return v;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Driver: inputs change on the falling edge; the state update is the next rising edge.
  task automatic drive(logic rst, logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                       logic iss, logic [AW-1:0] ia, logic fl,
                       logic [AW-1:0] ra1, logic [AW-1:0] ra2);
    @(negedge clk);
    reset = rst; RegWrite = we; WriteAddr = wa; WriteData = wd;
    Issue = iss; IssueAddr = ia; Flush = fl; ReadAddr1 = ra1; ReadAddr2 = ra2;
    #1;
  endtask

  // Behavioural reference model
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_rd(logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (RegWrite && WriteAddr == ra) return WriteData;
    return m_regs[ra];
  endfunction

  function automatic logic m_busy(logic [AW-1:0] ra);
    if (ra == 0) return 1'b0;
    if (RegWrite && WriteAddr == ra) return 1'b0;
    return m_pend[ra];
  endfunction

  task automatic m_step();
    if (reset) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    end else begin
      if (RegWrite && WriteAddr != 0) m_regs[WriteAddr] = WriteData;
      if (Flush) begin
        for (int i = 0; i < NR; i++) m_pend[i] = 0;
      end else begin
        if (RegWrite && WriteAddr != 0) m_pend[WriteAddr] = 0;
        if (Issue && IssueAddr != 0) m_pend[IssueAddr] = 1;
      end
    end
  endtask

  initial begin
    // Reset block
    reset = 1'b1; RegWrite = 0; WriteAddr = '0; WriteData = '0;
    Issue = 0; IssueAddr = '0; Flush = 0; ReadAddr1 = '0; ReadAddr2 = '0;
    repeat (2) @(negedge clk);

    //        rst we wa wd            iss ia fl ra1 ra2  e_rd1         e_rd2         b1 b2 cnt
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 0,  5,  32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 31, 5,  32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0, 0, 5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 5,  31, 32'hDEADBEEF, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        1, 7, 0, 7,  5,  32'h0,        32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 7,  7,  32'h0,        32'h0,        1, 1, 1));
    tbl.push_back(mk(0, 1, 7,  32'h12,       0, 0, 0, 7,  5,  32'h12,       32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 7,  7,  32'h12,       32'h12,       0, 0, 0));
    tbl.push_back(mk(0, 1, 3,  32'h55,       1, 3, 0, 3,  7,  32'h55,       32'h12,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 3,  0,  32'h55,       32'h0,        1, 0, 1));
    tbl.push_back(mk(0, 1, 0,  32'hFFFFFFFF, 1, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 0,  3,  32'h0,        32'h55,       0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        1, 1, 0, 3,  1,  32'h55,       32'h0,        1, 0, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        1, 2, 0, 1,  2,  32'h0,        32'h0,        1, 0, 2));
    tbl.push_back(mk(0, 0, 0,  32'h0,        1, 3, 0, 2,  3,  32'h0,        32'h55,       1, 1, 3));
    tbl.push_back(mk(0, 1, 9,  32'hA,        1, 10,1, 9,  1,  32'hA,        32'h0,        0, 1, 3));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 9,  10, 32'hA,        32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 1,  3,  32'h0,        32'h55,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        1, 6, 0, 6,  5,  32'h0,        32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4,  32'h1,        1, 8, 0, 0,  6,  32'h0,        32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 4,  5,  32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0, 0, 6,  8,  32'h0,        32'h0,        0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iss, tbl[i].ia,
            tbl[i].fl, tbl[i].ra1, tbl[i].ra2);
      check($sformatf("vec%0d rd1", i), ReadData1, tbl[i].e_rd1);
      check($sformatf("vec%0d rd2", i), ReadData2, tbl[i].e_rd2);
      check($sformatf("vec%0d busy1", i), DW'(Busy1), DW'(tbl[i].e_b1));
      check($sformatf("vec%0d busy2", i), DW'(Busy2), DW'(tbl[i].e_b2));
      check($sformatf("vec%0d cnt", i), DW'(PendingCount), DW'(tbl[i].e_cnt));
    end

    // Hand sequence: fill every non-zero register as pending to hit the
    // maximum count, then drain with writes back to zero.
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0);
    for (int i = 1; i < NR; i++) drive(0, 0, '0, '0, 1, AW'(i), 0, '0, '0);
    drive(0, 0, '0, '0, 1, AW'(0), 0, AW'(31), AW'(1));
    check("full cnt", DW'(PendingCount), DW'(NR - 1));
    check("full busy31", DW'(Busy1), 32'd1);
    for (int i = 1; i < NR; i++) drive(0, 1, AW'(i), DW'(i), 0, '0, 0, '0, '0);
    drive(0, 0, '0, '0, 0, '0, 0, AW'(31), AW'(17));
    check("drain cnt", DW'(PendingCount), 32'd0);
    check("drain rd31", ReadData1, 32'd31);
    check("drain rd17", ReadData2, 32'd17);

    // Random traffic against the model; start the model from a reset.
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0);
    m_step();
    for (int n = 0; n < 500; n++) begin
      logic [AW-1:0] wa, ia, r1, r2;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ia = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), wa, DW'($urandom),
            ($urandom_range(0, 2) != 0), ia, ($urandom_range(0, 15) == 0), r1, r2);
      check("rnd rd1", ReadData1, m_rd(ReadAddr1));
      check("rnd rd2", ReadData2, m_rd(ReadAddr2));
      check("rnd busy1", DW'(Busy1), DW'(m_busy(ReadAddr1)));
      check("rnd busy2", DW'(Busy2), DW'(m_busy(ReadAddr2)));
      check("rnd cnt", DW'(PendingCount), DW'(m_count()));
      m_step();
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_regfile_scoreboard
